// File: rtl/multi_bank_cmd_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_bank_cmd_scheduler_pkg: shared bank/command types and decode    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package multi_bank_cmd_scheduler_pkg;

  localparam int ADDR_BITS_DEF = 16;
  localparam int BA_BITS_DEF   = 3;

  typedef enum logic [3:0] {
    B_IDLE          = 4'd0,
    B_REFRESH_CHECK = 4'd1,
    B_ACT_CHECK     = 4'd2,
    B_ACTIVE        = 4'd3,
    B_ACT_STANDBY   = 4'd4,
    B_READ          = 4'd5,
    B_WRITE         = 4'd6,
    B_READA         = 4'd7,
    B_WRITEA        = 4'd8,
    B_PRE_CHECK     = 4'd9,
    B_PRE           = 4'd10
  } bank_state_t;

  typedef enum logic [2:0] {
    ATCMD_NOP       = 3'd0,
    ATCMD_ACTIVE    = 3'd1,
    ATCMD_READ      = 3'd2,
    ATCMD_WRITE     = 3'd3,
    ATCMD_READA     = 3'd4,
    ATCMD_WRITEA    = 3'd5,
    ATCMD_PRECHARGE = 3'd6,
    ATCMD_REFRESH   = 3'd7
  } sch_cmd_t;

  typedef struct packed {
    bank_state_t                state;
    logic [ADDR_BITS_DEF-1:0]   addr;
  } bank_info_t;

  localparam int BANK_STATE_W   = $bits(bank_state_t);
  localparam int SCH_CMD_W      = $bits(sch_cmd_t);
  localparam int BA_INFO_WIDTH  = $bits(bank_info_t);
  localparam int ISU_FIFO_WIDTH = SCH_CMD_W + ADDR_BITS_DEF + BA_BITS_DEF;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'd0,
    RW_READ  = 2'd1,
    RW_WRITE = 2'd2
  } rw_mode_t;

  typedef enum logic [2:0] {
    C0_REFRESH   = 3'd0,
    C1_STARVED   = 3'd1,
    C2_PRECHARGE = 3'd2,
    C3_COL_SAME  = 3'd3,
    C4_ACTIVATE  = 3'd4,
    C5_COL_OTHER = 3'd5
  } sch_class_t;

  localparam int NUM_CLASSES = 6;

  function automatic sch_cmd_t state_to_cmd(input bank_state_t s);
    case (s)
      B_ACTIVE:        return ATCMD_ACTIVE;
      B_READ:          return ATCMD_READ;
      B_WRITE:         return ATCMD_WRITE;
      B_READA:         return ATCMD_READA;
      B_WRITEA:        return ATCMD_WRITEA;
      B_PRE:           return ATCMD_PRECHARGE;
      B_REFRESH_CHECK: return ATCMD_REFRESH;
      default:         return ATCMD_NOP;
    endcase
  endfunction

  function automatic logic is_request(input bank_state_t s);
    return state_to_cmd(s) != ATCMD_NOP;
  endfunction

  function automatic logic is_check(input bank_state_t s);
    return (s == B_REFRESH_CHECK) || (s == B_ACT_CHECK) || (s == B_PRE_CHECK);
  endfunction

  function automatic logic is_read_state(input bank_state_t s);
    return (s == B_READ) || (s == B_READA);
  endfunction

  function automatic logic is_write_state(input bank_state_t s);
    return (s == B_WRITE) || (s == B_WRITEA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_bank_cmd_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter: first requester at or after ptr+1 (mod N), one-hot grant  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 8,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_bank_cmd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_bank_cmd_scheduler: class/RR arbitration of bank FSM commands   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multi_bank_cmd_scheduler
  import multi_bank_cmd_scheduler_pkg::*;
#(
  parameter int NUM_BANKS    = 8,
  parameter int ADDR_BITS    = 16,
  parameter int BA_BITS      = 3,
  parameter int AGE_W        = 8,
  parameter int AGE_THRESH   = 16,
  parameter int RW_BURST_MAX = 4,
  parameter int TFAW         = 20
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           isu_fifo_full,
  input  logic [NUM_BANKS*(BANK_STATE_W+ADDR_BITS)-1:0]  ba_info,
  output logic [NUM_BANKS-1:0]                           ba_stall,
  output logic [SCH_CMD_W+ADDR_BITS+BA_BITS-1:0]         sch_out,
  output logic                                           sch_issue
);

  localparam int BA_INFO_W = BANK_STATE_W + ADDR_BITS;
  localparam int OUT_W     = SCH_CMD_W + ADDR_BITS + BA_BITS;
  localparam int BURST_W   = $clog2(RW_BURST_MAX + 1);
  localparam int FAW_W     = (TFAW > 0) ? $clog2(TFAW + 1) : 1;
  localparam int FAW_SLOTS = 4;

  bank_state_t          bank_st   [NUM_BANKS];
  logic [ADDR_BITS-1:0] bank_addr [NUM_BANKS];

  logic [AGE_W-1:0]   age_q [NUM_BANKS];
  logic [AGE_W-1:0]   age_d [NUM_BANKS];
  logic [FAW_W-1:0]   faw_q [FAW_SLOTS];
  logic [FAW_W-1:0]   faw_d [FAW_SLOTS];
  logic [1:0]         faw_ptr_q, faw_ptr_d;
  rw_mode_t           rw_mode_q, rw_mode_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BA_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic               sch_issue_q, sch_issue_d;
  logic [OUT_W-1:0]   sch_out_q, sch_out_d;

  logic [NUM_BANKS-1:0]   class_req [NUM_CLASSES];
  logic [NUM_BANKS-1:0]   class_gnt [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] class_vld;

  logic                 faw_ok;
  logic                 cur_is_write;
  logic                 burst_ok;
  logic [NUM_BANKS-1:0] gnt_oh;
  logic                 gnt_vld;
  logic [BA_BITS-1:0]   gnt_idx;
  sch_cmd_t             gnt_cmd;
  logic [ADDR_BITS-1:0] gnt_addr;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_unpack
    assign bank_addr[b] = ba_info[b*BA_INFO_W +: ADDR_BITS];
    assign bank_st[b]   = bank_state_t'(ba_info[b*BA_INFO_W+ADDR_BITS +: BANK_STATE_W]);
  end

  always_comb begin
    faw_ok = (TFAW == 0);
    for (int s = 0; s < FAW_SLOTS; s++) begin
      if (faw_q[s] == '0) faw_ok = 1'b1;
    end
  end

  // Idle direction is treated as write so the first column of either kind
  // still has a defined "same direction" class.
  assign cur_is_write = (rw_mode_q != RW_READ);
  assign burst_ok     = (burst_q < BURST_W'(RW_BURST_MAX));

  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) class_req[k] = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      class_req[C0_REFRESH][b]   = (bank_st[b] == B_REFRESH_CHECK);
      // Starvation never overrides the activate window.
      class_req[C1_STARVED][b]   = is_request(bank_st[b]) &&
                                   (age_q[b] > AGE_W'(AGE_THRESH)) &&
                                   ((bank_st[b] != B_ACTIVE) || faw_ok);
      class_req[C2_PRECHARGE][b] = (bank_st[b] == B_PRE);
      class_req[C3_COL_SAME][b]  = burst_ok &&
                                   (cur_is_write ? is_write_state(bank_st[b])
                                                 : is_read_state(bank_st[b]));
      class_req[C4_ACTIVATE][b]  = (bank_st[b] == B_ACTIVE) && faw_ok;
      class_req[C5_COL_OTHER][b] = is_read_state(bank_st[b]) || is_write_state(bank_st[b]);
    end
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_class
    rr_arbiter #(
      .N     (NUM_BANKS),
      .PTR_W (BA_BITS)
    ) u_arb (
      .req   (class_req[k]),
      .ptr   (rr_ptr_q),
      .grant (class_gnt[k]),
      .valid (class_vld[k])
    );
  end

  always_comb begin
    gnt_oh  = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!isu_fifo_full) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        if (!gnt_vld && class_vld[k]) begin
          gnt_oh  = class_gnt[k];
          gnt_vld = 1'b1;
        end
      end
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (gnt_oh[b]) gnt_idx = BA_BITS'(b);
    end
  end

  assign gnt_cmd  = state_to_cmd(bank_st[gnt_idx]);
  assign gnt_addr = bank_addr[gnt_idx];
  assign ba_stall = ~gnt_oh;

  always_comb begin
    rw_mode_d   = rw_mode_q;
    burst_d     = burst_q;
    rr_ptr_d    = rr_ptr_q;
    faw_ptr_d   = faw_ptr_q;
    sch_out_d   = sch_out_q;
    sch_issue_d = gnt_vld;
    for (int s = 0; s < FAW_SLOTS; s++) begin
      faw_d[s] = (faw_q[s] != '0) ? faw_q[s] - 1'b1 : faw_q[s];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (gnt_oh[b] || bank_st[b] == B_IDLE || bank_st[b] == B_ACT_STANDBY)
        age_d[b] = '0;
      else if ((is_check(bank_st[b]) || is_request(bank_st[b])) && age_q[b] != '1)
        age_d[b] = age_q[b] + 1'b1;
      else
        age_d[b] = age_q[b];
    end
    if (gnt_vld) begin
      sch_out_d = {gnt_cmd, gnt_addr, gnt_idx};
      rr_ptr_d  = gnt_idx;
      case (gnt_cmd)
        ATCMD_READ, ATCMD_READA: begin
          rw_mode_d = RW_READ;
          burst_d   = (rw_mode_q != RW_READ) ? BURST_W'(1) :
                      burst_ok               ? burst_q + 1'b1 : burst_q;
        end
        ATCMD_WRITE, ATCMD_WRITEA: begin
          rw_mode_d = RW_WRITE;
          burst_d   = (rw_mode_q != RW_WRITE) ? BURST_W'(1) :
                      burst_ok                ? burst_q + 1'b1 : burst_q;
        end
        ATCMD_REFRESH: begin
          rw_mode_d = RW_IDLE;
          burst_d   = '0;
        end
        ATCMD_ACTIVE: begin
          faw_d[faw_ptr_q] = FAW_W'(TFAW);
          faw_ptr_d        = faw_ptr_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_mode_q   <= RW_IDLE;
      burst_q     <= '0;
      rr_ptr_q    <= '0;
      faw_ptr_q   <= '0;
      sch_issue_q <= 1'b0;
      sch_out_q   <= {ATCMD_NOP, {(ADDR_BITS+BA_BITS){1'b0}}};
      for (int b = 0; b < NUM_BANKS; b++) age_q[b] <= '0;
      for (int s = 0; s < FAW_SLOTS; s++) faw_q[s] <= '0;
    end else begin
      rw_mode_q   <= rw_mode_d;
      burst_q     <= burst_d;
      rr_ptr_q    <= rr_ptr_d;
      faw_ptr_q   <= faw_ptr_d;
      sch_issue_q <= sch_issue_d;
      sch_out_q   <= sch_out_d;
      for (int b = 0; b < NUM_BANKS; b++) age_q[b] <= age_d[b];
      for (int s = 0; s < FAW_SLOTS; s++) faw_q[s] <= faw_d[s];
    end
  end

  assign sch_out   = sch_out_q;
  assign sch_issue = sch_issue_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_bank_cmd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_bank_cmd_scheduler: directed + random bench with a model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_multi_bank_cmd_scheduler;
  import multi_bank_cmd_scheduler_pkg::*;

  localparam int NB     = 8;
  localparam int AB     = 16;
  localparam int BB     = 3;
  localparam int IW     = 4 + AB;
  localparam int OW     = 3 + AB + BB;
  localparam int THRESH = 16;
  localparam int BMAX   = 4;
  localparam int TFAW   = 20;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            isu_fifo_full;
  logic [NB*IW-1:0] ba_info;
  logic [NB-1:0]   ba_stall;
  logic [OW-1:0]   sch_out;
  logic            sch_issue;

  bank_state_t     st_in   [NB];
  logic [AB-1:0]   addr_in [NB];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit            checking = 1'b0;
  int            m_age [NB];
  int            m_rr, m_mode, m_cnt, m_cyc, m_grant;
  int            act_times [$];
  logic          m_issue;
  logic [OW-1:0] m_out;
  int            cls [NB];

  always #5 clk = ~clk;

  always_comb begin
    ba_info = '0;
    for (int b = 0; b < NB; b++) ba_info[b*IW +: IW] = {st_in[b], addr_in[b]};
  end

  multi_bank_cmd_scheduler #(
    .NUM_BANKS(NB), .ADDR_BITS(AB), .BA_BITS(BB), .AGE_W(8),
    .AGE_THRESH(THRESH), .RW_BURST_MAX(BMAX), .TFAW(TFAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .isu_fifo_full(isu_fifo_full),
    .ba_info(ba_info), .ba_stall(ba_stall), .sch_out(sch_out), .sch_issue(sch_issue)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [2:0] cmd_of(input bank_state_t s);
    case (s)
      B_ACTIVE:        return 3'd1;
      B_READ:          return 3'd2;
      B_WRITE:         return 3'd3;
      B_READA:         return 3'd4;
      B_WRITEA:        return 3'd5;
      B_PRE:           return 3'd6;
      B_REFRESH_CHECK: return 3'd7;
      default:         return 3'd0;
    endcase
  endfunction

  function automatic bit faw_eligible();
    int busy = 0;
    foreach (act_times[i]) if (m_cyc - act_times[i] <= TFAW) busy++;
    return busy < 4;
  endfunction

  // 0..5 = class, 6 = not grantable this cycle
  function automatic int class_of(input int b);
    bank_state_t s = st_in[b];
    bit rd = (s == B_READ) || (s == B_READA);
    bit wr = (s == B_WRITE) || (s == B_WRITEA);
    bit same = (m_mode == 1) ? rd : wr;
    if (s == B_REFRESH_CHECK) return 0;
    if (cmd_of(s) != 3'd0 && m_age[b] > THRESH && (s != B_ACTIVE || faw_eligible())) return 1;
    if (s == B_PRE) return 2;
    if (same && m_cnt < BMAX) return 3;
    if (s == B_ACTIVE && faw_eligible()) return 4;
    if (rd || wr) return 5;
    return 6;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) m_age[b] = 0;
    m_rr = 0; m_mode = 0; m_cnt = 0; m_cyc = 0; m_grant = -1;
    act_times.delete();
    m_issue = 1'b0;
    m_out   = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n && checking) begin
      int best, g, j;
      logic [NB-1:0] exp_stall;
      logic [2:0] c;
      best = 6;
      for (int b = 0; b < NB; b++) begin
        cls[b] = class_of(b);
        if (cls[b] < best) best = cls[b];
      end
      g = -1;
      if (!isu_fifo_full && best < 6) begin
        for (int i = 1; i <= NB; i++) begin
          j = (m_rr + i) % NB;
          if (g < 0 && cls[j] == best) g = j;
        end
      end
      exp_stall = '1;
      if (g >= 0) exp_stall[g] = 1'b0;
      chk("ba_stall", 64'(ba_stall), 64'(exp_stall));
      chk("sch_issue", 64'(sch_issue), 64'(m_issue));
      chk("sch_out", 64'(sch_out), 64'(m_out));

      for (int b = 0; b < NB; b++) begin
        if (b == g || st_in[b] == B_IDLE || st_in[b] == B_ACT_STANDBY) m_age[b] = 0;
        else if (m_age[b] < 255) m_age[b]++;
      end
      m_issue = (g >= 0);
      if (g >= 0) begin
        c = cmd_of(st_in[g]);
        m_out = {c, addr_in[g], 3'(g)};
        m_rr  = g;
        if (c == 3'd2 || c == 3'd4) begin
          m_cnt = (m_mode == 1) ? ((m_cnt < BMAX) ? m_cnt + 1 : BMAX) : 1;
          m_mode = 1;
        end else if (c == 3'd3 || c == 3'd5) begin
          m_cnt = (m_mode == 2) ? ((m_cnt < BMAX) ? m_cnt + 1 : BMAX) : 1;
          m_mode = 2;
        end else if (c == 3'd7) begin
          m_mode = 0; m_cnt = 0;
        end else if (c == 3'd1) begin
          act_times.push_back(m_cyc);
          if (act_times.size() > 4) void'(act_times.pop_front());
        end
      end
      m_grant = g;
      m_cyc++;
    end
  end

  // One scheduler cycle: model evaluates at negedge, inputs may change after posedge.
  task automatic cyc();
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    for (int b = 0; b < NB; b++) begin
      st_in[b]   = B_IDLE;
      addr_in[b] = 16'($urandom);
    end
    isu_fifo_full = 1'b0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int gs [8];
    int gcyc, gcyc2, pre_cyc, n_act;
    int act_cyc [6];

    rst_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_issue", 64'(sch_issue), 64'd0);
    chk("reset_stall", 64'(ba_stall), 64'hFF);
    chk("reset_out", 64'(sch_out), 64'd0);
    @(posedge clk); #3;
    rst_n    = 1'b1;
    checking = 1'b1;
    idle(2);

    // Round robin from rr_ptr=0 across three activates
    for (int b = 0; b < 3; b++) st_in[b] = B_ACTIVE;
    for (int k = 0; k < 3; k++) begin
      cyc();
      gs[k] = m_grant;
      if (m_grant >= 0) st_in[m_grant] = B_ACT_STANDBY;
    end
    chk("rr_first", 64'(gs[0]), 64'd1);
    chk("rr_second", 64'(gs[1]), 64'd2);
    chk("rr_third", 64'(gs[2]), 64'd0);
    idle(25);

    // Write streak then opposite direction
    st_in[3] = B_WRITE;
    st_in[5] = B_READ;
    for (int k = 0; k < 5; k++) begin
      cyc();
      gs[k] = m_grant;
      if (m_grant == 5) st_in[5] = B_ACT_STANDBY;
    end
    for (int k = 0; k < 4; k++) chk("streak_write", 64'(gs[k]), 64'd3);
    chk("streak_read", 64'(gs[4]), 64'd5);
    chk("streak_mode", 64'(m_mode), 64'd1);
    chk("streak_cnt", 64'(m_cnt), 64'd1);
    idle(2);

    // Starvation behind continuous precharges
    st_in[0] = B_PRE;
    st_in[1] = B_PRE;
    st_in[7] = B_READ;
    gcyc = -1; gcyc2 = -1;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (m_grant == 7) begin
        if (gcyc < 0) gcyc = k;
        else if (gcyc2 < 0) gcyc2 = k;
      end
    end
    chk("starve_cycle", 64'(gcyc), 64'd17);
    chk("starve_age_cleared", 64'(gcyc2 - gcyc), 64'd18);
    idle(25);

    // Rolling four-activate window with a precharge in the gap
    for (int b = 0; b < 6; b++) st_in[b] = B_ACTIVE;
    n_act = 0; pre_cyc = -1;
    for (int k = 0; k < 6; k++) act_cyc[k] = -1;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (m_grant >= 0 && m_grant < 6) begin
        if (n_act < 6) act_cyc[n_act] = k;
        n_act++;
        st_in[m_grant] = B_ACT_STANDBY;
      end else if (m_grant == 6) begin
        pre_cyc = k;
        st_in[6] = B_ACT_STANDBY;
      end
      if (k == 5) st_in[6] = B_PRE;
    end
    for (int k = 0; k < 4; k++) chk("faw_early_act", 64'(act_cyc[k]), 64'(k));
    chk("faw_fifth_not_early", 64'(act_cyc[4] >= TFAW), 64'd1);
    chk("faw_all_granted", 64'(n_act), 64'd6);
    chk("faw_pre_in_gap", 64'(pre_cyc), 64'd6);
    idle(25);

    // FIFO full holds arbitration state
    st_in[2] = B_READ;
    cyc();
    chk("full_setup", 64'(m_grant), 64'd2);
    st_in[4] = B_READ;
    isu_fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("full_no_grant", 64'(m_grant + 1), 64'd0);
    end
    isu_fifo_full = 1'b0;
    cyc();
    chk("full_resume", 64'(m_grant), 64'd4);
    idle(2);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < NB; b++) begin
        if ((b == m_grant && $urandom_range(0, 3) != 0) || $urandom_range(0, 9) == 0) begin
          st_in[b]   = bank_state_t'(4'($urandom_range(0, 10)));
          addr_in[b] = 16'($urandom);
        end
      end
      isu_fifo_full = ($urandom_range(0, 9) == 0);
      cyc();
    end

    // Asynchronous reset right after a grant
    set_idle();
    st_in[0] = B_PRE;
    cyc();
    chk("pre_reset_issue", 64'(sch_issue), 64'd1);
    #2;
    checking = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("async_reset_issue", 64'(sch_issue), 64'd0);
    chk("async_reset_out", 64'(sch_out), 64'd0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
